rxdet_sequencer: RTL and testbench
==================================

// Module: rxdet_sequencer
// PURPOSE
//  Controller for the receiver-detect datapath of one LTSSM port (DSP or USP).
//  Drives per-lane rx_det_seq_req, collects rx_det_seq_ack from the link partner and decides the detected-lane mask.
//  Sequences Detect.Quiet -> Detect.Active, with one confirmation re-probe and bounded retries.
//  Optionally schedules electrical-idle break on detected lanes. Sits between LTSSM Detect logic and lane PHY sideband.
// PARAMETERS
//  NUM_LANES       4     number of lanes
//  QUIET_CYCLES    100   cycles in QUIET before each probe
//  ACTIVE_TIMEOUT  1200  max cycles a probe waits for acks (> partner round-trip of 500+)
//  MAX_ATTEMPTS    4     QUIET/ACTIVE attempts before fail, range 1..15
//  IDLE_BREAK_DLY  500   cycles from done to idle_break assertion (macro only)
//  CNT_W           11    width of shared cycle counter; must hold max(QUIET_CYCLES,ACTIVE_TIMEOUT,IDLE_BREAK_DLY)
// PORTS
//  clk          in   1          single clock
//  rst          in   1          asynchronous, active-low reset
//  start        in   1          pulse: begin detect; ignored while busy
//  abort        in   1          sync abort to IDLE; wins over every other event
//  lane_en      in   NUM_LANES  lanes allowed to probe; sampled on accepted start
//  det_ack      in   NUM_LANES  rx_det_seq_ack from partner, level
//  det_req      out  NUM_LANES  rx_det_seq_req per lane
//  det_mask     out  NUM_LANES  detected lanes, valid from done until next start
//  busy         out  1          high from accepted start until done or abort
//  done         out  1          one-cycle completion pulse
//  fail         out  1          MAX_ATTEMPTS exhausted with no confirmed lane; held like det_mask
//  attempt      out  4          current attempt number, 0 in IDLE
//  idle_break   out  NUM_LANES  electrical-idle break per detected lane
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counter 0; latched lane_en 0.
//  States: IDLE, QUIET, ACTIVE1, CONFIRM_QUIET, ACTIVE2, REPORT.
//  IDLE --start & !busy--> QUIET: latch lane_en; clear det_mask and fail; set attempt=1; busy=1 next cycle.
//    lane_en==0 at start: go directly to REPORT; fail=1, det_mask=0.
//  QUIET: counter runs QUIET_CYCLES cycles, then -> ACTIVE1. det_req=0.
//  ACTIVE1/ACTIVE2: det_req = latched lane_en, registered, asserted from the first cycle in the state.
//    Sticky hit[i] sets when det_ack[i] & det_req[i]. Acks on disabled lanes are ignored.
//    Probe ends early when hit==lane_en, else at ACTIVE_TIMEOUT cycles. det_req drops the cycle after the probe ends.
//  ACTIVE1 end:
//    hit==lane_en -> REPORT, mask=hit.
//    hit==0 -> retry.
//    partial -> CONFIRM_QUIET, save hit1.
//  CONFIRM_QUIET: QUIET_CYCLES cycles, then -> ACTIVE2 with hit cleared.
//  ACTIVE2 end:
//    hit==hit1 -> REPORT, mask=hit1 (partial link).
//    otherwise -> retry.
//  retry: attempt<MAX_ATTEMPTS -> attempt+1, QUIET; else REPORT with fail=1, mask=0.
//  REPORT: one cycle; done=1, busy=0 next cycle; -> IDLE. start in REPORT cycle is ignored.
//  abort: any state -> IDLE next cycle. Clears det_req, busy, attempt; no done. det_mask and fail keep old values.
//  start and abort in the same cycle: abort wins.
//  Counter: saturating, cleared on every state change; no wrap.
// CONFIGURATION
//  RXDET_IDLE_BREAK_EN defined:
//    after done with fail=0, wait IDLE_BREAK_DLY cycles, then idle_break = det_mask, held.
//    Cleared by accepted start, abort or reset.
//  RXDET_IDLE_BREAK_EN undefined: idle_break tied 0; delay counter logic absent.
// STRUCTURE
//  Package ltssm_rxdet_pkg:
//    state enum with 3-bit encoding;
//    default timing constants (QUIET/ACTIVE/IDLE_BREAK);
//    ATTEMPT_W=4.
//  Sub-module rxdet_timer: loadable CNT_W-bit down-counter with clear and expire flag.
//    One instance for state timing; a second instance only under RXDET_IDLE_BREAK_EN.
// TESTING
//  T1 all lanes ack: lane_en=4'hF, partner acks all lanes 520 cycles after req.
//     -> done at about QUIET+521; det_mask=4'hF; fail=0; attempt=1.
//  T2 partial link: lane_en=4'hF, only lanes 0 and 1 ack in both probes.
//     -> CONFIRM_QUIET taken; det_mask=4'h3; fail=0.
//  T3 no partner: det_ack=0 throughout, MAX_ATTEMPTS=4.
//     -> 4 x (QUIET+ACTIVE_TIMEOUT) cycles, then done; fail=1; det_mask=0.
//  T4 inconsistent: probe 1 acks 4'h3, probe 2 acks 4'h1.
//     -> retry; attempt=2; final mask follows later consistent attempts.
//  T5 abort and reset mid-ACTIVE1:
//     abort -> det_req=0 and busy=0 next cycle; no done.
//     rst low mid-probe -> all outputs 0 immediately, asynchronously.
//  T6 macro on: after T1, idle_break=4'hF exactly IDLE_BREAK_DLY cycles after done; stays 0 after T3.

Source files
------------

// File: rtl/ltssm_rxdet_pkg.sv
// Shared types and default timing for the receiver-detect sequencer.
// The optional idle-break feature is enabled by defining RXDET_IDLE_BREAK_EN.
package ltssm_rxdet_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_QUIET         = 3'd1,
    ST_ACTIVE1       = 3'd2,
    ST_CONFIRM_QUIET = 3'd3,
    ST_ACTIVE2       = 3'd4,
    ST_REPORT        = 3'd5
  } rxdet_state_e;

  // Default timing in clock cycles.
  localparam int DEF_QUIET_CYCLES   = 100;
  localparam int DEF_ACTIVE_TIMEOUT = 1200;
  localparam int DEF_IDLE_BREAK_DLY = 500;
  localparam int DEF_CNT_W          = 11;

  // Width of the attempt counter (attempts 1..15).
  localparam int ATTEMPT_W = 4;

endpackage

// File: rtl/rxdet_timer.sv
// Loadable saturating down-counter; expire flag is high while the count is zero.
module rxdet_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority over load; the count holds at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/rxdet_sequencer.sv
// Receiver-detect sequencer: Quiet -> Active probe, confirmation re-probe,
// bounded retries, detected-lane mask. Optional electrical-idle break
// scheduling is built when RXDET_IDLE_BREAK_EN is defined.
module rxdet_sequencer
  import ltssm_rxdet_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int QUIET_CYCLES   = DEF_QUIET_CYCLES,
  parameter int ACTIVE_TIMEOUT = DEF_ACTIVE_TIMEOUT,
  parameter int MAX_ATTEMPTS   = 4,
  parameter int IDLE_BREAK_DLY = DEF_IDLE_BREAK_DLY,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [NUM_LANES-1:0] i_lane_en,
  input  logic [NUM_LANES-1:0] i_det_ack,
  output logic [NUM_LANES-1:0] o_det_req,
  output logic [NUM_LANES-1:0] o_det_mask,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fail,
  output logic [ATTEMPT_W-1:0] o_attempt,
  output logic [NUM_LANES-1:0] o_idle_break
);

  localparam logic [CNT_W-1:0]     L_QUIET_LD  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0]     L_ACTIVE_LD = CNT_W'(ACTIVE_TIMEOUT - 1);
  localparam logic [ATTEMPT_W-1:0] L_MAX_ATT   = ATTEMPT_W'(MAX_ATTEMPTS);

  rxdet_state_e         r_state, w_state_next;
  logic [NUM_LANES-1:0] r_lane_en, w_lane_en_next;
  logic [NUM_LANES-1:0] r_det_req, w_det_req_next;
  logic [NUM_LANES-1:0] r_hit, w_hit_next;
  logic [NUM_LANES-1:0] r_hit1, w_hit1_next;
  logic [NUM_LANES-1:0] r_det_mask, w_det_mask_next;
  logic                 r_fail, w_fail_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [ATTEMPT_W-1:0] r_attempt, w_attempt_next;

  logic [NUM_LANES-1:0] w_hit_now;
  logic                 w_probe_end;
  logic                 w_retry;
  logic                 w_start_acc;
  logic                 w_ib_arm;
  logic                 w_tmr_clr, w_tmr_load, w_tmr_exp;
  logic [CNT_W-1:0]     w_tmr_val;

  // Hits seen so far including this cycle; only lanes being probed count.
  assign w_hit_now   = r_hit | (i_det_ack & r_det_req);
  assign w_probe_end = (w_hit_now == r_lane_en) || w_tmr_exp;

  rxdet_timer #(.CNT_W(CNT_W)) u_state_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_exp)
  );

  // Next-state and next-output logic; abort overrides everything at the end.
  always_comb begin
    w_state_next    = r_state;
    w_lane_en_next  = r_lane_en;
    w_det_req_next  = r_det_req;
    w_hit_next      = r_hit;
    w_hit1_next     = r_hit1;
    w_det_mask_next = r_det_mask;
    w_fail_next     = r_fail;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_attempt_next  = r_attempt;
    w_retry         = 1'b0;
    w_start_acc     = 1'b0;
    w_ib_arm        = 1'b0;
    w_tmr_clr       = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc     = 1'b1;
          w_lane_en_next  = i_lane_en;
          w_det_mask_next = '0;
          w_fail_next     = 1'b0;
          w_attempt_next  = ATTEMPT_W'(1);
          w_busy_next     = 1'b1;
          w_hit_next      = '0;
          if (i_lane_en == '0) begin
            // Nothing to probe: report failure straight away.
            w_state_next = ST_REPORT;
            w_fail_next  = 1'b1;
            w_done_next  = 1'b1;
            w_tmr_clr    = 1'b1;
          end else begin
            w_state_next = ST_QUIET;
            w_tmr_load   = 1'b1;
            w_tmr_val    = L_QUIET_LD;
          end
        end
      end
      ST_QUIET: begin
        if (w_tmr_exp) begin
          w_state_next   = ST_ACTIVE1;
          w_det_req_next = r_lane_en;
          w_hit_next     = '0;
          w_tmr_load     = 1'b1;
          w_tmr_val      = L_ACTIVE_LD;
        end
      end
      ST_ACTIVE1: begin
        w_hit_next = w_hit_now;
        if (w_probe_end) begin
          w_det_req_next = '0;
          if (w_hit_now == r_lane_en) begin
            w_state_next    = ST_REPORT;
            w_det_mask_next = w_hit_now;
            w_done_next     = 1'b1;
            w_ib_arm        = 1'b1;
            w_tmr_clr       = 1'b1;
          end else if (w_hit_now == '0) begin
            w_retry = 1'b1;
          end else begin
            // Partial link: remember it and confirm with a second probe.
            w_state_next = ST_CONFIRM_QUIET;
            w_hit1_next  = w_hit_now;
            w_tmr_load   = 1'b1;
            w_tmr_val    = L_QUIET_LD;
          end
        end
      end
      ST_CONFIRM_QUIET: begin
        if (w_tmr_exp) begin
          w_state_next   = ST_ACTIVE2;
          w_det_req_next = r_lane_en;
          w_hit_next     = '0;
          w_tmr_load     = 1'b1;
          w_tmr_val      = L_ACTIVE_LD;
        end
      end
      ST_ACTIVE2: begin
        w_hit_next = w_hit_now;
        if (w_probe_end) begin
          w_det_req_next = '0;
          if (w_hit_now == r_hit1) begin
            w_state_next    = ST_REPORT;
            w_det_mask_next = r_hit1;
            w_done_next     = 1'b1;
            w_ib_arm        = 1'b1;
            w_tmr_clr       = 1'b1;
          end else begin
            w_retry = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        // Single completion cycle; a start here is deliberately dropped.
        w_state_next   = ST_IDLE;
        w_busy_next    = 1'b0;
        w_attempt_next = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_retry) begin
      if (r_attempt < L_MAX_ATT) begin
        w_state_next   = ST_QUIET;
        w_attempt_next = r_attempt + 1'b1;
        w_tmr_load     = 1'b1;
        w_tmr_val      = L_QUIET_LD;
      end else begin
        w_state_next    = ST_REPORT;
        w_fail_next     = 1'b1;
        w_det_mask_next = '0;
        w_done_next     = 1'b1;
        w_tmr_clr       = 1'b1;
      end
    end

    if (i_abort) begin
      w_state_next    = ST_IDLE;
      w_lane_en_next  = r_lane_en;
      w_det_req_next  = '0;
      w_det_mask_next = r_det_mask;
      w_fail_next     = r_fail;
      w_busy_next     = 1'b0;
      w_done_next     = 1'b0;
      w_attempt_next  = '0;
      w_start_acc     = 1'b0;
      w_ib_arm        = 1'b0;
      w_tmr_clr       = 1'b1;
      w_tmr_load      = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lane_en  <= '0;
      r_det_req  <= '0;
      r_hit      <= '0;
      r_hit1     <= '0;
      r_det_mask <= '0;
      r_fail     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_attempt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_lane_en  <= w_lane_en_next;
      r_det_req  <= w_det_req_next;
      r_hit      <= w_hit_next;
      r_hit1     <= w_hit1_next;
      r_det_mask <= w_det_mask_next;
      r_fail     <= w_fail_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_attempt  <= w_attempt_next;
    end
  end

  assign o_det_req  = r_det_req;
  assign o_det_mask = r_det_mask;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_fail     = r_fail;
  assign o_attempt  = r_attempt;

`ifdef RXDET_IDLE_BREAK_EN
  localparam logic [CNT_W-1:0] L_IB_LD = CNT_W'(IDLE_BREAK_DLY - 1);

  logic                 r_ib_armed;
  logic [NUM_LANES-1:0] r_idle_break;
  logic                 w_ib_exp;
  logic                 w_ib_clr;

  assign w_ib_clr = w_start_acc | i_abort;

  rxdet_timer #(.CNT_W(CNT_W)) u_ib_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_ib_clr),
    .i_load     (w_ib_arm),
    .i_load_val (L_IB_LD),
    .o_expired  (w_ib_exp)
  );

  // Arm on successful done; drive the mask onto idle_break once the delay elapses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ib_armed   <= 1'b0;
      r_idle_break <= '0;
    end else if (w_ib_clr) begin
      r_ib_armed   <= 1'b0;
      r_idle_break <= '0;
    end else if (w_ib_arm) begin
      r_ib_armed   <= 1'b1;
    end else if (r_ib_armed && w_ib_exp) begin
      r_ib_armed   <= 1'b0;
      r_idle_break <= r_det_mask;
    end
  end

  assign o_idle_break = r_idle_break;
`else
  logic w_unused_ib;
  assign w_unused_ib  = w_ib_arm ^ w_start_acc ^ (IDLE_BREAK_DLY == 0);
  assign o_idle_break = '0;
`endif

endmodule

// File: tb/tb_rxdet_sequencer.sv
// Directed bench for rxdet_sequencer with a simple link-partner model:
// the partner raises det_ack (masked by ack_mask) ACK_DLY cycles after det_req rises.
module tb_rxdet_sequencer;

  localparam int NL      = 4;
  localparam int ACK_DLY = 520;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NL-1:0] lane_en;
  logic [NL-1:0] det_ack;
  logic [NL-1:0] det_req;
  logic [NL-1:0] det_mask;
  logic          busy;
  logic          done;
  logic          fail;
  logic [3:0]    attempt;
  logic [NL-1:0] idle_break;

  logic [NL-1:0] ack_mask;
  int            req_cnt;
  int            cyc;
  int            n_checks;
  int            n_errors;
  int            t0;
  int            t1;
  int            t2;
  int            n_done;

  rxdet_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_lane_en    (lane_en),
    .i_det_ack    (det_ack),
    .o_det_req    (det_req),
    .o_det_mask   (det_mask),
    .o_busy       (busy),
    .o_done       (done),
    .o_fail       (fail),
    .o_attempt    (attempt),
    .o_idle_break (idle_break)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            req_cnt <= 0;
    else if (det_req != 0) req_cnt <= req_cnt + 1;
    else                   req_cnt <= 0;
  end

  assign det_ack = (req_cnt >= ACK_DLY) ? ack_mask : '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [NL-1:0] en);
    lane_en = en;
    start   = 1'b1;
    step();
    start   = 1'b0;
    t0      = cyc;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    check(tag, done, 1'b1);
    t1 = cyc;
  endtask

  task automatic wait_req(input logic want, input int limit, input string tag);
    int n;
    n = 0;
    while (((det_req != 0) != want) && n < limit) begin
      step();
      n++;
    end
    check(tag, (det_req != 0), want);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0; t0 = 0; t1 = 0; t2 = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; lane_en = '0; ack_mask = '0;
    repeat (3) step();
    check("rst_outputs", {det_req, det_mask, busy, done, fail, attempt, idle_break}, 0);
    rst_n = 1'b1;
    step();
    check("idle_after_rst", {busy, attempt}, 0);

    // T1: all lanes ack
    ack_mask = 4'hF;
    pulse_start(4'hF);
    check("t1_busy_attempt", {busy, attempt, det_req}, {1'b1, 4'd1, 4'd0});
    wait_done(2000, "t1_done_seen");
    $display("T1 all lanes: done after %0d cycles mask=%h fail=%b attempt=%0d", t1 - t0, det_mask, fail, attempt);
    check("t1_latency", t1 - t0, 621);
    check("t1_mask", det_mask, 4'hF);
    check("t1_fail", fail, 0);
    check("t1_attempt", attempt, 1);
    step();
    check("t1_after", {busy, done, attempt, det_mask}, {1'b0, 1'b0, 4'd0, 4'hF});
`ifdef RXDET_IDLE_BREAK_EN
    begin
      int n;
      n = 0;
      while (idle_break == 0 && n < 1000) begin
        step();
        n++;
      end
      t2 = cyc;
    end
    $display("T6 idle_break=%h after %0d cycles", idle_break, t2 - t1);
    check("t6_ib_delay", t2 - t1, 500);
    check("t6_ib_value", idle_break, 4'hF);
`else
    repeat (600) step();
    check("t6_ib_off", idle_break, 0);
`endif

    // T2: partial link, lanes 0/1 consistent; a start while busy is ignored
    ack_mask = 4'h3;
    pulse_start(4'hF);
    check("t2_ib_cleared", idle_break, 0);
    repeat (50) step();
    lane_en = 4'h0; start = 1'b1; step(); start = 1'b0;
    check("t2_start_ignored", {busy, attempt}, {1'b1, 4'd1});
    wait_done(4000, "t2_done_seen");
    $display("T2 partial: done after %0d cycles mask=%h fail=%b", t1 - t0, det_mask, fail);
    check("t2_latency", t1 - t0, 2600);
    check("t2_mask", det_mask, 4'h3);
    check("t2_fail", fail, 0);
    step();

    // T4: inconsistent probes then a full detect on attempt 2
    ack_mask = 4'h3;
    pulse_start(4'hF);
    wait_req(1'b1, 300, "t4_req1_up");
    wait_req(1'b0, 1500, "t4_req1_down");
    ack_mask = 4'h1;
    wait_req(1'b1, 300, "t4_req2_up");
    wait_req(1'b0, 1500, "t4_req2_down");
    check("t4_retry_attempt", attempt, 2);
    ack_mask = 4'hF;
    wait_done(2000, "t4_done_seen");
    $display("T4 inconsistent: done after %0d cycles mask=%h attempt=%0d", t1 - t0, det_mask, attempt);
    check("t4_latency", t1 - t0, 3221);
    check("t4_mask_attempt", {det_mask, attempt, fail}, {4'hF, 4'd2, 1'b0});
    step();

    // T3: no partner, attempts exhausted
    ack_mask = 4'h0;
    pulse_start(4'hF);
    wait_done(6000, "t3_done_seen");
    $display("T3 no partner: done after %0d cycles mask=%h fail=%b attempt=%0d", t1 - t0, det_mask, fail, attempt);
    check("t3_latency", t1 - t0, 5200);
    check("t3_result", {det_mask, fail, attempt}, {4'h0, 1'b1, 4'd4});
    repeat (600) step();
    check("t3_no_ib", idle_break, 0);

    // Acks on disabled lanes are ignored
    ack_mask = 4'hF;
    pulse_start(4'h3);
    wait_done(2000, "t7_done_seen");
    $display("T7 lane_en=3: done after %0d cycles mask=%h", t1 - t0, det_mask);
    check("t7_latency", t1 - t0, 621);
    check("t7_mask", det_mask, 4'h3);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mask", {det_mask, fail}, 0);
    step();
    rst_n = 1'b1;
    step();

    // lane_en == 0 reports failure at once; start in REPORT is ignored
    pulse_start(4'h0);
    $display("T8 lane_en=0: done=%b fail=%b mask=%h busy=%b", done, fail, det_mask, busy);
    check("t8_report", {done, fail, det_mask, busy}, {1'b1, 1'b1, 4'h0, 1'b1});
    lane_en = 4'hF; start = 1'b1; step(); start = 1'b0;
    check("t8_start_in_report", {busy, attempt, fail}, {1'b0, 4'd0, 1'b1});

    // T5: abort mid-ACTIVE1, no done afterwards
    pulse_start(4'hF);
    wait_req(1'b1, 300, "t5_req_up");
    repeat (10) step();
    abort = 1'b1; step(); abort = 1'b0;
    $display("T5 abort: det_req=%h busy=%b attempt=%0d", det_req, busy, attempt);
    check("t5_abort", {det_req, busy, attempt, done}, 0);
    for (int i = 0; i < 700; i++) begin
      step();
      if (done) n_done++;
    end
    check("t5_no_done", n_done, 0);

    // start and abort together: abort wins
    lane_en = 4'hF; start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("start_abort", {busy, attempt}, 0);

    // Asynchronous reset mid-probe
    pulse_start(4'hF);
    wait_req(1'b1, 300, "t5_req_up2");
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    $display("T5 reset: det_req=%h busy=%b attempt=%0d", det_req, busy, attempt);
    check("t5_async_rst", {det_req, det_mask, busy, done, fail, attempt, idle_break}, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
